// File: rtl/bcd_tally_pkg.sv
// Shared types and helpers for the BCD tally arbiter: FSM encoding, BCD digit
// limits and the round-robin pick function.
package bcd_tally_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    INC   = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  // First set request strictly after ptr, wrapping modulo nreq; ptr itself is
  // checked last so a lone requester can be granted back-to-back.
  function automatic logic [2:0] next_rr(input logic [2:0] ptr,
                                         input logic [7:0] req,
                                         input int         nreq);
    logic [2:0] pick;
    logic       found;
    int         idx;
    pick  = ptr;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idx = (int'(ptr) + i) % nreq;
      if (i <= nreq && !found && req[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/bcd_decade.sv
// One BCD decade of the tally: counts 0..9 on inc_in, carries out when it
// rolls from 9 back to 0.
module bcd_decade
  import bcd_tally_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset,
  input  logic       clear,
  input  logic       inc_in,
  output logic [3:0] digit,
  output logic       carry_out
);

  assign carry_out = inc_in && (digit == BCD_MAX);

  // Any code at or above 9 rolls to zero, so 10..15 can never persist.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      digit <= BCD_ZERO;
    end else if (clear) begin
      digit <= BCD_ZERO;
    end else if (inc_in) begin
      digit <= (digit >= BCD_MAX) ? BCD_ZERO : digit + 4'd1;
    end
  end

endmodule

// File: rtl/bcd_tally_arbiter.sv
// Round-robin arbiter sharing one cascaded BCD tally among NREQ requesters.
// Define BCD_TALLY_SATURATE_EN to hold the tally at all-9s with a sticky Wrap.
module bcd_tally_arbiter
  import bcd_tally_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DIGITS = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Clear,
  input  logic                  Enable,
  input  logic [NREQ-1:0]       Req,
  output logic [NREQ-1:0]       Ack,
  output logic [2:0]            GrantId,
  output logic                  Busy,
  output logic [4*DIGITS-1:0]   Tally,
  output logic                  Wrap
);

  state_t            state;
  logic              inc_fire;
  logic              inc0;
  logic              wrap_hit;
  logic [DIGITS:0]   carry;
  logic [NREQ-1:0]   ack_nxt;

  assign Busy     = (state != IDLE);
  assign inc_fire = (state == INC) && !Clear;
  assign ack_nxt  = NREQ'(1) << GrantId;

`ifdef BCD_TALLY_SATURATE_EN
  logic all9;

  always_comb begin
    all9 = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (Tally[4*d +: 4] != BCD_MAX) all9 = 1'b0;
    end
  end

  // At all-9s the increment is swallowed; the Ack still goes out.
  assign inc0     = inc_fire && !all9;
  assign wrap_hit = inc_fire && all9;
`else
  assign inc0     = inc_fire;
  assign wrap_hit = carry[DIGITS];
`endif

  assign carry[0] = inc0;

  for (genvar g = 0; g < DIGITS; g++) begin : g_decade
    bcd_decade u_decade (
      .Clock     (Clock),
      .Reset     (Reset),
      .clear     (Clear),
      .inc_in    (carry[g]),
      .digit     (Tally[4*g +: 4]),
      .carry_out (carry[g+1])
    );
  end

  // Ack and Wrap are registered so they coincide with the updated Tally.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      GrantId <= 3'(NREQ - 1);
      Ack     <= '0;
      Wrap    <= 1'b0;
    end else if (Clear) begin
      state   <= IDLE;
      Ack     <= '0;
      Wrap    <= 1'b0;
    end else begin
      Ack <= (state == INC) ? ack_nxt : '0;
`ifdef BCD_TALLY_SATURATE_EN
      Wrap <= Wrap | wrap_hit;
`else
      Wrap <= wrap_hit;
`endif
      case (state)
        IDLE: begin
          if (Enable && (|Req)) begin
            state   <= GRANT;
            GrantId <= next_rr(GrantId, 8'(Req), NREQ);
          end
        end
        GRANT:   state <= INC;
        INC:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_tally_arbiter.sv
// Directed bench for bcd_tally_arbiter: transaction-level model checked every
// cycle, plus hand-computed expectations along the directed sequence.
module tb_bcd_tally_arbiter;

  localparam int NREQ   = 4;
  localparam int DIGITS = 2;
  localparam int MAXV   = 10**DIGITS - 1;

  logic                 Clock = 1'b0;
  logic                 Reset;
  logic                 Clear;
  logic                 Enable;
  logic [NREQ-1:0]      Req;
  logic [NREQ-1:0]      Ack;
  logic [2:0]           GrantId;
  logic                 Busy;
  logic [4*DIGITS-1:0]  Tally;
  logic                 Wrap;

  int total = 0;
  int bad   = 0;

  bcd_tally_arbiter #(.NREQ(NREQ), .DIGITS(DIGITS)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Clear   (Clear),
    .Enable  (Enable),
    .Req     (Req),
    .Ack     (Ack),
    .GrantId (GrantId),
    .Busy    (Busy),
    .Tally   (Tally),
    .Wrap    (Wrap)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    int p;
    p = v;
    r = '0;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(p % 10);
      p = p / 10;
    end
    return r;
  endfunction

  // Model: m_left counts cycles until the committed count lands (2 = just
  // granted, 1 = about to count), m_cnt is the tally as a plain integer.
  int              m_left = 0;
  int              m_gid  = NREQ - 1;
  int              m_cnt  = 0;
  logic [NREQ-1:0] m_ack  = '0;
  logic            m_wrap = 1'b0;

  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      m_left = 0; m_gid = NREQ - 1; m_cnt = 0; m_ack = '0; m_wrap = 1'b0;
    end else if (Clear) begin
      m_left = 0; m_cnt = 0; m_ack = '0; m_wrap = 1'b0;
    end else begin
      m_ack = '0;
`ifndef BCD_TALLY_SATURATE_EN
      m_wrap = 1'b0;
`endif
      if (m_left == 1) begin
        m_ack[m_gid] = 1'b1;
        if (m_cnt == MAXV) begin
`ifndef BCD_TALLY_SATURATE_EN
          m_cnt = 0;
`endif
          m_wrap = 1'b1;
        end else begin
          m_cnt = m_cnt + 1;
        end
        m_left = 0;
      end else if (m_left == 2) begin
        m_left = 1;
      end else if (Enable && (|Req)) begin
        for (int k = 1; k <= NREQ; k++) begin
          if (Req[(m_gid + k) % NREQ]) begin
            m_gid = (m_gid + k) % NREQ;
            break;
          end
        end
        m_left = 2;
      end
    end
  end

  always @(negedge Clock) begin
    chk("ack", 32'(Ack), 32'(m_ack));
    chk("grant_id", 32'(GrantId), 32'(m_gid));
    chk("busy", 32'(Busy), 32'(m_left != 0));
    chk("tally", 32'(Tally), 32'(to_bcd(m_cnt)));
    chk("wrap", 32'(Wrap), 32'(m_wrap));
    for (int d = 0; d < DIGITS; d++) chk("digit_range", 32'(Tally[4*d +: 4] <= 4'd9), 32'd1);
  end

  task automatic tick();
    @(posedge Clock);
    #2;
  endtask

  task automatic wait_ack(input int budget, output int n, output logic [NREQ-1:0] seen);
    n    = 0;
    seen = '0;
    while (n < budget && seen == '0) begin
      tick();
      n++;
      if (Ack != '0) seen = Ack;
    end
    if (seen == '0) begin
      total++;
      bad++;
      $display("FAIL ack_timeout: no Ack within %0d cycles at %0t", budget, $time);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
  endtask

  int              n;
  logic [NREQ-1:0] seen;

  initial begin
    Reset = 1'b1; Clear = 1'b0; Enable = 1'b1; Req = '0;
    #1;
    Reset = 1'b0;
    Req   = 4'b0001;
    #2;
    chk("rst_tally", 32'(Tally), 32'h0);
    chk("rst_gid", 32'(GrantId), 32'd3);
    chk("rst_ack", 32'(Ack), 32'h0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_wrap", 32'(Wrap), 32'd0);
    #37;
    Reset = 1'b1;

    // Single requester held: one count per three cycles.
    for (int i = 0; i < 3; i++) begin
      wait_ack(6, n, seen);
      chk("t1_latency", 32'(n), 32'd3);
      chk("t1_ack", 32'(seen), 32'h1);
      chk("t1_tally", 32'(Tally), 32'(i + 1));
    end
    tick();
    chk("t1_ack_pulse", 32'(Ack), 32'h0);

    // All four requesting: strict rotation from requester 0.
    Req = 4'b1111;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      wait_ack(6, n, seen);
      chk("t2_order", 32'(seen), 32'(1 << (i % 4)));
    end
    chk("t2_tally", 32'(Tally), 32'h08);

    // Fill to 99, then one more.
    Req = 4'b0001;
    do_reset();
    for (int i = 0; i < 99; i++) wait_ack(6, n, seen);
    chk("t3_full", 32'(Tally), 32'h99);
    chk("t3_no_wrap_yet", 32'(Wrap), 32'd0);
    wait_ack(6, n, seen);
    chk("t3_ack", 32'(seen), 32'h1);
    chk("t3_wrap", 32'(Wrap), 32'd1);
`ifdef BCD_TALLY_SATURATE_EN
    chk("t3_tally_sat", 32'(Tally), 32'h99);
`else
    chk("t3_tally_wrap", 32'(Tally), 32'h00);
`endif
    tick();
    Req = '0;
`ifdef BCD_TALLY_SATURATE_EN
    chk("t3_wrap_sticky", 32'(Wrap), 32'd1);
`else
    chk("t3_wrap_pulse", 32'(Wrap), 32'd0);
`endif
    wait_ack(6, n, seen);
    chk("t3_drop_in_grant", 32'(n), 32'd2);
`ifdef BCD_TALLY_SATURATE_EN
    chk("t3_tally2", 32'(Tally), 32'h99);
    chk("t3_wrap2", 32'(Wrap), 32'd1);
`else
    chk("t3_tally2", 32'(Tally), 32'h01);
    chk("t3_wrap2", 32'(Wrap), 32'd0);
`endif
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    chk("t3_clr_tally", 32'(Tally), 32'h00);
    chk("t3_clr_wrap", 32'(Wrap), 32'd0);

    // Clear while requester 2 is in GRANT.
    Req = 4'b0001;
    wait_ack(6, n, seen);
    chk("t4_pre_tally", 32'(Tally), 32'h01);
    Req = 4'b0100;
    tick();
    chk("t4_busy", 32'(Busy), 32'd1);
    chk("t4_gid", 32'(GrantId), 32'd2);
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    chk("t4_no_ack", 32'(Ack), 32'h0);
    chk("t4_tally", 32'(Tally), 32'h00);
    chk("t4_idle", 32'(Busy), 32'd0);
    chk("t4_gid_kept", 32'(GrantId), 32'd2);
    wait_ack(6, n, seen);
    chk("t4_regrant", 32'(seen), 32'h4);
    chk("t4_latency", 32'(n), 32'd3);
    Req = 4'b0010;
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    Req = '0;
    chk("t4_clr_wins", 32'(Busy), 32'd0);
    chk("t4_clr_tally", 32'(Tally), 32'h00);
    tick();

    // Enable low blocks new grants only.
    Enable = 1'b0;
    Req = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t5_blocked", 32'({Busy, Ack}), 32'h0);
    end
    Enable = 1'b1;
    wait_ack(6, n, seen);
    chk("t5_latency", 32'(n), 32'd3);
    chk("t5_ack", 32'(seen), 32'h4);
    Req = 4'b0001;
    tick();
    Enable = 1'b0;
    Req = '0;
    wait_ack(6, n, seen);
    chk("t5_inflight", 32'(n), 32'd2);
    chk("t5_tally", 32'(Tally), 32'h02);
    Enable = 1'b1;

    // Reset dropped while in INC.
    Req = 4'b0010;
    tick();
    tick();
    chk("t6_busy", 32'(Busy), 32'd1);
    Reset = 1'b0;
    #1;
    chk("t6_tally", 32'(Tally), 32'h00);
    chk("t6_ack", 32'(Ack), 32'h0);
    chk("t6_gid", 32'(GrantId), 32'd3);
    Req = '0;
    tick();
    chk("t6_no_late_ack", 32'(Ack), 32'h0);
    Reset = 1'b1;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
